adder_result_accum: RTL and testbench

Downstream consumer of the 4-bit adder stage. It taps the adder's operand-valid strobe and its registered 7-bit result `c`, and sums `NUM_RESULTS` consecutive results into one saturating frame total. Each total is presented on a valid/ready output handshake, and the block flags any frame lost to back-pressure. It sits between the adder and the result-reporting logic.

---
 rtl/adder_result_accum.sv | 141 ++++++++++++++
 tb/tb_adder_result_accum.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_accum.sv
// rtl/adder_result_accum.sv - frame accumulator of adder results with saturating total and valid/ready output
module adder_result_accum #(
    parameter int NUM_RESULTS = 4,
    parameter int ACC_WIDTH   = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [6:0]           c,
    output logic [ACC_WIDTH-1:0] sum_data,
    output logic                 sum_sat,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic                 overrun,
    output logic [7:0]           frames_done
);

    localparam logic [7:0]           LAST_IDX = 8'(NUM_RESULTS - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = '1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   pend;
    logic [ACC_WIDTH-1:0]   acc;
    logic [7:0]             cnt;
    logic                   sat_f;
    logic [ACC_WIDTH:0]     sum_wide;
    logic                   sum_ovf;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   sat_next;
    logic                   frame_done;
    logic                   load_out;
    logic                   drop;

    assign sum_valid = (state_q == S_FULL);

    // Running sum with one extra bit so a carry out means the frame saturated
    always_comb begin
        sum_wide   = {1'b0, acc} + {{(ACC_WIDTH - 6){1'b0}}, c};
        sum_ovf    = sum_wide[ACC_WIDTH];
        acc_next   = sum_ovf ? ACC_MAX : sum_wide[ACC_WIDTH-1:0];
        sat_next   = sat_f | sum_ovf;
        frame_done = pend && (cnt == LAST_IDX);
    end

    // Output handshake: load on completion unless a held total is still unaccepted
    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        drop     = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (frame_done) begin
                    load_out = 1'b1;
                    state_d  = S_FULL;
                end
            end
            S_FULL: begin
                if (frame_done) begin
                    if (sum_ready) begin
                        load_out = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (sum_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Handshake state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // The adder's result lands one cycle after its valid, so delay the strobe to line up with c
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend <= 1'b0;
        end else begin
            pend <= in_valid;
        end
    end

    // Frame accumulation; the completing sample clears state so the next sample opens a new frame
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc   <= '0;
            cnt   <= '0;
            sat_f <= 1'b0;
        end else if (pend) begin
            if (frame_done) begin
                acc   <= '0;
                cnt   <= '0;
                sat_f <= 1'b0;
            end else begin
                acc   <= acc_next;
                cnt   <= cnt + 8'd1;
                sat_f <= sat_next;
            end
        end
    end

    // Output register holds the accepted-pending total stable while FULL
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_data <= '0;
            sum_sat  <= 1'b0;
        end else if (load_out) begin
            sum_data <= acc_next;
            sum_sat  <= sat_next;
        end
    end

    // Frame counter counts every completion, dropped or not; overrun is sticky
    always_ff @(posedge clk) begin
        if (!reset) begin
            frames_done <= 8'd0;
            overrun     <= 1'b0;
        end else begin
            if (frame_done) begin
                frames_done <= frames_done + 8'd1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_result_accum.sv
// tb/tb_adder_result_accum.sv - self-checking bench for adder_result_accum
module tb_adder_result_accum;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [6:0] c;
    logic       sum_ready;

    logic [8:0] d0, d2;
    logic [7:0] d1;
    logic       s0, s1, s2, v0, v1, v2, o0, o1, o2;
    logic [7:0] f0, f1, f2;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    adder_result_accum #(.NUM_RESULTS(4), .ACC_WIDTH(9)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .c(c),
        .sum_data(d0), .sum_sat(s0), .sum_valid(v0), .sum_ready(sum_ready),
        .overrun(o0), .frames_done(f0));

    adder_result_accum #(.NUM_RESULTS(4), .ACC_WIDTH(8)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .c(c),
        .sum_data(d1), .sum_sat(s1), .sum_valid(v1), .sum_ready(sum_ready),
        .overrun(o1), .frames_done(f1));

    adder_result_accum #(.NUM_RESULTS(1), .ACC_WIDTH(9)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .c(c),
        .sum_data(d2), .sum_sat(s2), .sum_valid(v2), .sum_ready(sum_ready),
        .overrun(o2), .frames_done(f2));

    // Reference: true (unbounded) frame sums, clamped only when a frame is reported
    int m_n[3] = '{4, 4, 1};
    int m_w[3] = '{9, 8, 9};
    int m_sum[3], m_cnt[3], m_data[3], m_frames[3];
    bit m_sat[3], m_full[3], m_ovr[3];
    bit m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  maxv, tot;
        bit  comp, st;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_sum[i] = 0; m_cnt[i] = 0; m_data[i] = 0; m_frames[i] = 0;
                m_sat[i] = 0; m_full[i] = 0; m_ovr[i] = 0;
            end
            m_pend = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                comp = 0;
                tot  = 0;
                st   = 0;
                if (m_pend) begin
                    m_sum[i] += int'(c);
                    m_cnt[i]++;
                    if (m_cnt[i] == m_n[i]) begin
                        maxv = (1 << m_w[i]) - 1;
                        st   = (m_sum[i] > maxv);
                        tot  = st ? maxv : m_sum[i];
                        comp = 1;
                        m_sum[i] = 0;
                        m_cnt[i] = 0;
                        m_frames[i] = (m_frames[i] + 1) % 256;
                    end
                end
                if (comp) begin
                    if (!m_full[i] || sum_ready) begin
                        m_data[i] = tot;
                        m_sat[i]  = st;
                        m_full[i] = 1;
                    end else begin
                        m_ovr[i] = 1;
                    end
                end else if (m_full[i] && sum_ready) begin
                    m_full[i] = 0;
                end
            end
            m_pend = in_valid;
        end
    endtask

    task automatic check_all();
        logic [31:0] od, os, ov, oo, of;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin od = 32'(d0); os = 32'(s0); ov = 32'(v0); oo = 32'(o0); of = 32'(f0); end
                1: begin od = 32'(d1); os = 32'(s1); ov = 32'(v1); oo = 32'(o1); of = 32'(f1); end
                default: begin od = 32'(d2); os = 32'(s2); ov = 32'(v2); oo = 32'(o2); of = 32'(f2); end
            endcase
            chk($sformatf("u%0d.sum_valid", i), ov, 32'(m_full[i]));
            chk($sformatf("u%0d.overrun", i), oo, 32'(m_ovr[i]));
            chk($sformatf("u%0d.frames_done", i), of, 32'(m_frames[i]));
            if (m_full[i]) begin
                chk($sformatf("u%0d.sum_data", i), od, 32'(m_data[i]));
                chk($sformatf("u%0d.sum_sat", i), os, 32'(m_sat[i]));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #2;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'($urandom);
            c        = 7'($urandom);
            cycle();
        end
        reset    = 1'b1;
        in_valid = 1'b0;
    endtask

    // Valid strobes for each value, with c presented one cycle after its strobe
    task automatic burst(input int cv[$], input bit rdy_last);
        for (int k = 0; k <= cv.size(); k++) begin
            in_valid = (k < cv.size());
            c        = (k > 0) ? 7'(cv[k-1]) : 7'($urandom);
            if (k == cv.size()) sum_ready = rdy_last;
            cycle();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int q[$];
        int ones[$];
        int twos[$];
        reset = 1'b0; in_valid = 1'b0; c = 7'd0; sum_ready = 1'b0;
        ones = {1, 1, 1, 1};
        twos = {2, 2, 2, 2};

        do_reset();
        chk("reset.sum_valid", 32'(v0), 0);
        chk("reset.sum_data", 32'(d0), 0);
        chk("reset.frames_done", 32'(f0), 0);
        chk("reset.overrun", 32'(o0), 0);

        // Basic frame
        sum_ready = 1'b1;
        q = {10, 20, 30, 40};
        burst(q, 1'b1);
        chk("basic.sum_valid", 32'(v0), 1);
        chk("basic.sum_data", 32'(d0), 100);
        chk("basic.sum_sat", 32'(s0), 0);
        chk("basic.frames_done", 32'(f0), 1);
        c = 7'($urandom);
        cycle();
        chk("basic.one_cycle", 32'(v0), 0);

        // Saturation on the 8-bit accumulator
        do_reset();
        sum_ready = 1'b1;
        q = {127, 127, 127, 127};
        burst(q, 1'b1);
        chk("sat.sum_data", 32'(d1), 255);
        chk("sat.sum_sat", 32'(s1), 1);
        chk("sat.wide_data", 32'(d0), 508);
        burst(ones, 1'b1);
        chk("sat.next_data", 32'(d1), 4);
        chk("sat.next_sat", 32'(s1), 0);

        // Back-pressure and overrun
        do_reset();
        sum_ready = 1'b0;
        burst(ones, 1'b0);
        burst(twos, 1'b0);
        chk("bp.sum_data", 32'(d0), 4);
        chk("bp.overrun", 32'(o0), 1);
        chk("bp.frames_done", 32'(f0), 2);
        sum_ready = 1'b1;
        cycle();
        chk("bp.drained", 32'(v0), 0);

        // Accept and completion on the same edge
        do_reset();
        sum_ready = 1'b0;
        burst(ones, 1'b0);
        chk("simul.first", 32'(d0), 4);
        burst(twos, 1'b1);
        chk("simul.sum_valid", 32'(v0), 1);
        chk("simul.sum_data", 32'(d0), 8);
        chk("simul.overrun", 32'(o0), 0);

        // Reset mid-frame, with a pending sample killed by reset
        do_reset();
        sum_ready = 1'b1;
        in_valid = 1'b1; c = 7'($urandom); cycle();
        c = 7'd5; cycle();
        reset = 1'b0; c = 7'd5; cycle();
        reset = 1'b1; in_valid = 1'b0; c = 7'd99; cycle();
        chk("rst.no_sample", 32'(f2), 0);
        burst(ones, 1'b1);
        chk("rst.sum_data", 32'(d0), 4);
        chk("rst.frames_done", 32'(f0), 1);

        // Single-result frames and frame counter wrap
        do_reset();
        sum_ready = 1'b1;
        q = {};
        for (int k = 0; k < 256; k++) q.push_back(int'($urandom_range(0, 127)));
        burst(q, 1'b1);
        chk("wrap.frames_done", 32'(f2), 0);
        chk("wrap.overrun", 32'(o2), 0);
        chk("wrap.last_total", 32'(d2), 32'(q[255]));
        chk("wrap.u0_frames", 32'(f0), 64);

        // Random traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            reset     = ($urandom_range(0, 199) != 0);
            in_valid  = 1'($urandom);
            c         = 7'($urandom);
            sum_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
